// File: rtl/bht_update_queue.sv
// bht_update_queue: buffers resolved conditional-branch outcomes and drains
// them in order, one per cycle, into the BHT update port.
// bht_update_o is a packed {valid, pc[VLEN-1:0], taken} vector. Its field
// order matches the struct, so the port width stays tied to VLEN.
module bht_update_queue #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned VLEN  = 64
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         flush_i,
  input  logic                         debug_mode_i,
  input  logic                         resolve_valid_i,
  output logic                         resolve_ready_o,
  input  logic [VLEN-1:0]              resolve_pc_i,
  input  logic                         resolve_taken_i,
  input  logic                         bht_busy_i,
  output logic [VLEN+1:0]              bht_update_o,
  output logic [$clog2(DEPTH+1)-1:0]   occupancy_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH+1);

  logic [PW-1:0]   rd_ptr;
  logic [PW-1:0]   wr_ptr;
  logic [CW-1:0]   count;
  logic [VLEN-1:0] pc_mem    [DEPTH];
  logic            taken_mem [DEPTH];

  logic            out_valid;
  logic [VLEN-1:0] out_pc;
  logic            out_taken;

  logic            push;
  logic            pop;
  logic            full;

  // Ready comes only from registered count (plus reset), never from bht_busy_i.
  // In debug mode the handshake completes, but push stays low, so the entry is dropped.
  always_comb begin
    full            = (count == CW'(DEPTH));
    resolve_ready_o = ~rst_i & ~full;
    push            = resolve_valid_i & resolve_ready_o & ~flush_i & ~debug_mode_i;
    pop             = (count != '0) & ~bht_busy_i & ~flush_i;
  end

  // Entry storage has no reset. Only slots between rd_ptr and wr_ptr are ever read.
  always_ff @(posedge clk_i) begin
    if (push) begin
      pc_mem[wr_ptr]    <= resolve_pc_i;
      taken_mem[wr_ptr] <= resolve_taken_i;
    end
  end

  // Pointers and count. Flush clears them and overrides any push or pop in that cycle.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush_i) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // Registered update port. valid pulses once per popped entry; pc/taken hold otherwise.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      out_valid <= 1'b0;
      out_pc    <= '0;
      out_taken <= 1'b0;
    end else begin
      out_valid <= pop;
      if (pop) begin
        out_pc    <= pc_mem[rd_ptr];
        out_taken <= taken_mem[rd_ptr];
      end
    end
  end

  assign bht_update_o = {out_valid, out_pc, out_taken};
  assign occupancy_o  = count;

endmodule

// File: tb/tb_bht_update_queue.sv
// Directed bench for bht_update_queue: single push latency, full/back-pressure,
// steady push+pop with pointer wrap, debug-mode drop, flush, and async reset.
module tb_bht_update_queue;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned VLEN  = 64;
  localparam int unsigned OW    = VLEN + 2;

  logic            clk_i = 1'b0;
  logic            rst_i;
  logic            flush_i;
  logic            debug_mode_i;
  logic            resolve_valid_i;
  logic            resolve_ready_o;
  logic [VLEN-1:0] resolve_pc_i;
  logic            resolve_taken_i;
  logic            bht_busy_i;
  logic [OW-1:0]   bht_update_o;
  logic [2:0]      occupancy_o;

  int checks = 0;
  int errors = 0;

  bht_update_queue #(.DEPTH(DEPTH), .VLEN(VLEN)) dut (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .flush_i         (flush_i),
    .debug_mode_i    (debug_mode_i),
    .resolve_valid_i (resolve_valid_i),
    .resolve_ready_o (resolve_ready_o),
    .resolve_pc_i    (resolve_pc_i),
    .resolve_taken_i (resolve_taken_i),
    .bht_busy_i      (bht_busy_i),
    .bht_update_o    (bht_update_o),
    .occupancy_o     (occupancy_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [OW-1:0] upd(input logic v, input logic [VLEN-1:0] pc, input logic t);
    return {v, pc, t};
  endfunction

  task automatic check(input string tag, input logic [OW-1:0] obs, input logic [OW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge, then settle 1 time unit past it.
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic offer(input logic v, input logic [VLEN-1:0] pc, input logic t);
    resolve_valid_i = v;
    resolve_pc_i    = pc;
    resolve_taken_i = t;
  endtask

  initial begin
    logic [VLEN-1:0] seq [10];
    rst_i = 1'b1; flush_i = 1'b0; debug_mode_i = 1'b0; bht_busy_i = 1'b0;
    offer(1'b0, '0, 1'b0);
    #1;
    check("rst_ready", OW'(resolve_ready_o), OW'(0));
    step(); step();
    check("rst_out",  bht_update_o, '0);
    check("rst_occ",  OW'(occupancy_o), OW'(0));
    rst_i = 1'b0;
    #1;
    check("rst_rel_ready", OW'(resolve_ready_o), OW'(1));

    // 1: single push. Output is visible two edges after the push, for one cycle.
    offer(1'b1, 64'h8000_0010, 1'b1);
    step();
    offer(1'b0, '0, 1'b0);
    check("t1_occ1",  OW'(occupancy_o), OW'(1));
    check("t1_nv",    OW'(bht_update_o[OW-1]), OW'(0));
    step();
    check("t1_out",   bht_update_o, upd(1'b1, 64'h8000_0010, 1'b1));
    check("t1_occ0",  OW'(occupancy_o), OW'(0));
    step();
    check("t1_drop",  bht_update_o, upd(1'b0, 64'h8000_0010, 1'b1));

    // 2: fill while busy, then drain in order.
    bht_busy_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("t2_ready_pre", OW'(resolve_ready_o), OW'(1));
      offer(1'b1, 64'h100 + 64'(4 * i), 1'(i));
      step();
    end
    check("t2_ready_full", OW'(resolve_ready_o), OW'(0));
    check("t2_occ4",       OW'(occupancy_o), OW'(4));
    offer(1'b1, 64'hBAD, 1'b1);
    step();
    check("t2_occ_hold",   OW'(occupancy_o), OW'(4));
    check("t2_busy_nv",    OW'(bht_update_o[OW-1]), OW'(0));
    offer(1'b0, '0, 1'b0);
    bht_busy_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      check("t2_drain", bht_update_o, upd(1'b1, 64'h100 + 64'(4 * i), 1'(i)));
      check("t2_occ",   OW'(occupancy_o), OW'(3 - i));
    end
    step();
    check("t2_end_nv", OW'(bht_update_o[OW-1]), OW'(0));

    // 3: hold count at 2 with a push and a pop every cycle; the pointers wrap.
    for (int i = 0; i < 10; i++) seq[i] = 64'h200 + 64'(4 * i);
    bht_busy_i = 1'b1;
    for (int i = 0; i < 2; i++) begin
      offer(1'b1, seq[i], 1'(i));
      step();
    end
    check("t3_occ2", OW'(occupancy_o), OW'(2));
    bht_busy_i = 1'b0;
    for (int i = 0; i < 8; i++) begin
      offer(1'b1, seq[i + 2], 1'(i));
      step();
      check("t3_occ",  OW'(occupancy_o), OW'(2));
      check("t3_out",  bht_update_o, upd(1'b1, seq[i], 1'(i)));
    end
    offer(1'b0, '0, 1'b0);
    for (int i = 8; i < 10; i++) begin
      step();
      check("t3_tail", bht_update_o, upd(1'b1, seq[i], 1'(i - 8)));
    end
    step();
    check("t3_empty", {bht_update_o[OW-1], 62'd0, occupancy_o}, OW'(0));

    // 4: debug mode completes handshakes but stores nothing.
    debug_mode_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      offer(1'b1, 64'h500 + 64'(4 * i), 1'b1);
      #1;
      check("t4_ready", OW'(resolve_ready_o), OW'(1));
      step();
      check("t4_occ",   OW'(occupancy_o), OW'(0));
      check("t4_nv",    OW'(bht_update_o[OW-1]), OW'(0));
    end
    offer(1'b0, '0, 1'b0);
    debug_mode_i = 1'b0;
    step();
    check("t4_after_nv", OW'(bht_update_o[OW-1]), OW'(0));

    // 5: flush at count 3 with a concurrent push. Neither the push nor the old entries appear.
    bht_busy_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      offer(1'b1, 64'h600 + 64'(4 * i), 1'b0);
      step();
    end
    check("t5_occ3", OW'(occupancy_o), OW'(3));
    bht_busy_i = 1'b0;
    flush_i    = 1'b1;
    offer(1'b1, 64'hDEAD, 1'b1);
    step();
    flush_i = 1'b0;
    offer(1'b0, '0, 1'b0);
    check("t5_occ0", OW'(occupancy_o), OW'(0));
    check("t5_nv",   OW'(bht_update_o[OW-1]), OW'(0));
    step();
    check("t5_nv2",  OW'(bht_update_o[OW-1]), OW'(0));
    offer(1'b1, 64'h700, 1'b1);
    step();
    offer(1'b0, '0, 1'b0);
    step();
    check("t5_fresh", bht_update_o, upd(1'b1, 64'h700, 1'b1));

    // 6: async reset while count is 2 and the output is valid.
    bht_busy_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      offer(1'b1, 64'h800 + 64'(4 * i), 1'b1);
      step();
    end
    offer(1'b0, '0, 1'b0);
    bht_busy_i = 1'b0;
    step();
    check("t6_pre_out", bht_update_o, upd(1'b1, 64'h800, 1'b1));
    check("t6_pre_occ", OW'(occupancy_o), OW'(2));
    #2 rst_i = 1'b1;
    #1;
    check("t6_occ",   OW'(occupancy_o), OW'(0));
    check("t6_out",   bht_update_o, '0);
    check("t6_ready", OW'(resolve_ready_o), OW'(0));
    step();
    check("t6_ready_hold", OW'(resolve_ready_o), OW'(0));
    check("t6_out_hold",   bht_update_o, '0);
    #2 rst_i = 1'b0;
    #1;
    check("t6_ready_rel", OW'(resolve_ready_o), OW'(1));
    step();
    check("t6_no_partial", {bht_update_o[OW-1], 62'd0, occupancy_o}, OW'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete, expected finish");
    $fatal(1, "timeout");
  end

endmodule
